// File: rtl/ps2_mouse_accumulator.sv
// Accumulates PS/2 packet motion with saturation and emits clamped 9-bit deltas plus buttons
// once per SAMPLE_DIV cycles; packets need 2 cycles to reach the accumulators, with no stall.
module ps2_mouse_accumulator #(
  parameter int SAMPLE_DIV = 1000000,
  parameter bit INVERT_Y   = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  output logic [8:0]  mouse_x,
  output logic [8:0]  mouse_y,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        mouse_middle,
  output logic        input_pulse
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_DIV - 1);

  function automatic logic signed [8:0] decode_axis(input logic [7:0] mag, input logic sign,
                                                    input logic ovf);
    if (ovf) return sign ? 9'sh100 : 9'sd255;
    return {sign, mag};
  endfunction

  // -(-256) is not representable in 9 bits, so it pins to the positive limit.
  function automatic logic signed [8:0] negate9(input logic signed [8:0] v);
    if (v == 9'sh100) return 9'sd255;
    return -v;
  endfunction

  function automatic logic signed [13:0] sx12(input logic signed [11:0] v);
    return {{2{v[11]}}, v};
  endfunction

  function automatic logic signed [13:0] sx9(input logic signed [8:0] v);
    return {{5{v[8]}}, v};
  endfunction

  function automatic logic signed [11:0] sat12(input logic signed [13:0] v);
    if (v > 14'sd2047) return 12'sd2047;
    if (v < -14'sd2048) return 12'sh800;
    return v[11:0];
  endfunction

  function automatic logic signed [8:0] clamp9(input logic signed [11:0] v);
    if (v > 12'sd255) return 9'sd255;
    if (v < -12'sd256) return 9'sh100;
    return v[8:0];
  endfunction

  logic                 tgl_ref_q, tgl_ref_d;
  logic                 dec_vld_q, dec_vld_d;
  logic signed [8:0]    dec_dx_q, dec_dx_d;
  logic signed [8:0]    dec_dy_q, dec_dy_d;
  logic [2:0]           dec_btn_q, dec_btn_d;
  logic signed [11:0]   acc_x_q, acc_x_d;
  logic signed [11:0]   acc_y_q, acc_y_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [2:0]           btn_q, btn_d;
  logic [2:0]           last_btn_q, last_btn_d;
  logic signed [8:0]    mouse_x_q, mouse_x_d;
  logic signed [8:0]    mouse_y_q, mouse_y_d;
  logic                 pulse_q, pulse_d;

  logic                 pkt_det;
  logic                 tmr_tc;
  logic                 emit;
  logic signed [8:0]    raw_y;
  logic signed [8:0]    emit_x, emit_y;
  logic signed [13:0]   sum_x, sum_y;
  logic                 unused_sync_bit;

  // Status bit 3 is the PS/2 always-one framing bit and carries no information.
  assign unused_sync_bit = ps2_mouse[3];

  always_comb begin
    pkt_det   = ps2_mouse[24] ^ tgl_ref_q;
    tgl_ref_d = ps2_mouse[24];

    dec_vld_d = pkt_det;
    dec_dx_d  = decode_axis(ps2_mouse[15:8], ps2_mouse[4], ps2_mouse[6]);
    raw_y     = decode_axis(ps2_mouse[23:16], ps2_mouse[5], ps2_mouse[7]);
    dec_dy_d  = INVERT_Y ? negate9(raw_y) : raw_y;
    dec_btn_d = ps2_mouse[2:0];

    tmr_tc = (tmr_q == TMR_LAST);
    tmr_d  = tmr_tc ? '0 : tmr_q + 1'b1;

    emit   = tmr_tc && ((acc_x_q != 12'sd0) || (acc_y_q != 12'sd0) || (btn_q != last_btn_q));
    emit_x = clamp9(acc_x_q);
    emit_y = clamp9(acc_y_q);

    // The emitted share leaves the pre-add accumulator; a same-cycle packet lands on the remainder.
    sum_x = sx12(acc_x_q) - (emit ? sx9(emit_x) : 14'sd0) + (dec_vld_q ? sx9(dec_dx_q) : 14'sd0);
    sum_y = sx12(acc_y_q) - (emit ? sx9(emit_y) : 14'sd0) + (dec_vld_q ? sx9(dec_dy_q) : 14'sd0);
    acc_x_d = sat12(sum_x);
    acc_y_d = sat12(sum_y);

    btn_d      = dec_vld_q ? dec_btn_q : btn_q;
    last_btn_d = emit ? btn_q : last_btn_q;
    mouse_x_d  = emit ? emit_x : mouse_x_q;
    mouse_y_d  = emit ? emit_y : mouse_y_q;
    pulse_d    = pulse_q ^ emit;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Tracking the live toggle through reset hides any packet that arrives meanwhile.
      tgl_ref_q  <= ps2_mouse[24];
      dec_vld_q  <= 1'b0;
      dec_dx_q   <= '0;
      dec_dy_q   <= '0;
      dec_btn_q  <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      tmr_q      <= '0;
      btn_q      <= '0;
      last_btn_q <= '0;
      mouse_x_q  <= '0;
      mouse_y_q  <= '0;
      pulse_q    <= 1'b0;
    end else begin
      tgl_ref_q  <= tgl_ref_d;
      dec_vld_q  <= dec_vld_d;
      dec_dx_q   <= dec_dx_d;
      dec_dy_q   <= dec_dy_d;
      dec_btn_q  <= dec_btn_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      tmr_q      <= tmr_d;
      btn_q      <= btn_d;
      last_btn_q <= last_btn_d;
      mouse_x_q  <= mouse_x_d;
      mouse_y_q  <= mouse_y_d;
      pulse_q    <= pulse_d;
    end
  end

  assign mouse_x      = mouse_x_q;
  assign mouse_y      = mouse_y_q;
  assign mouse_left   = btn_q[0];
  assign mouse_right  = btn_q[1];
  assign mouse_middle = btn_q[2];
  assign input_pulse  = pulse_q;

endmodule

// File: doc/ps2_mouse_accumulator.md
Name: ps2_mouse_accumulator

Overview:
Sits directly upstream of the mouse-port emulation. It takes the raw 3-byte PS/2 mouse packets delivered by the HPS I/O bus and accumulates their motion deltas with saturation. At a fixed sample rate it emits clamped signed 9-bit deltas plus button state to the port emulation, with a toggle strobe. This decouples host USB/PS/2 packet rate from the emulated machine's update rate, and no motion is lost between samples.

Parameters:
SAMPLE_DIV, 1000000, clk_sys cycles per emit opportunity (>=4)
INVERT_Y, 1, 1 = negate PS/2 Y so positive means screen-down

Ports:
clk_sys  in  1  system clock, same domain as HPS I/O
reset  in  1  synchronous active-high reset
ps2_mouse  in  25  [7:0] status, [15:8] dX, [23:16] dY, [24] toggles once per new packet
mouse_x  out  9  signed emitted X delta, two's complement
mouse_y  out  9  signed emitted Y delta, two's complement
mouse_left  out  1  left button, 1 = pressed
mouse_right  out  1  right button, 1 = pressed
mouse_middle  out  1  middle button, 1 = pressed
input_pulse  out  1  toggles once per emitted sample

Behaviour:
- Reset (synchronous, active-high):
  - mouse_x, mouse_y, buttons, input_pulse = 0.
  - acc_x, acc_y = 0; sample timer = 0.
  - last_btn = 0.
  - Toggle reference register loads ps2_mouse[24], so no packet is detected on reset release.
  - A packet arriving during reset is discarded.
- Packet detect: new packet when ps2_mouse[24] differs from the registered reference. The reference updates every cycle.
- Decode, registered, 1 cycle after detect:
  - raw_x = {status[4], dX}; raw_y = {status[5], dY} (9-bit signed).
  - If status[6] (X overflow) is set, raw_x = +255 if status[4]=0, else -256. status[7] does the same for Y.
  - If INVERT_Y, dy = -raw_y. -(-256) clamps to +255.
  - Buttons: status[0] left, status[1] right, status[2] middle. Button outputs update in the same cycle the delta is added, i.e. 2 cycles after the toggle edge.
- Accumulators: acc_x and acc_y are 12-bit signed. Each add saturates to [-2048, +2047]; no wrap-around.
- Sample timer counts 0..SAMPLE_DIV-1 and wraps. At terminal count it is an emit opportunity.
- Emit conditions: acc_x != 0, or acc_y != 0, or current buttons != last_btn.
- On emit, in one cycle:
  - mouse_x = clamp(acc_x, -256, +255); mouse_y likewise.
  - acc_x -= mouse_x; acc_y -= mouse_y. The remainder carries to the next sample.
  - last_btn = buttons; input_pulse toggles.
  - mouse_x/mouse_y update in the same cycle as the toggle and hold until the next emit.
- No emit: outputs hold and input_pulse does not toggle.
- Same-cycle decode add and emit:
  - The emitted value uses acc before the add.
  - Next acc = sat(acc - emitted + delta).
  - Button change from that packet is compared on the next opportunity.
- Back-to-back packets (toggle changes on consecutive cycles) must each be captured. The decode stage is a single register with no stall, and the HPS side is guaranteed >=2 cycles apart.
- The timer runs continuously regardless of packet activity.

Test Plan:
- Reset behaviour: hold reset with ps2_mouse[24]=1, release, run 2*SAMPLE_DIV cycles with no packets -> no input_pulse toggle, all outputs 0.
- Single packet: status=0x08, dX=0x10, dY=0x05, INVERT_Y=1 -> at next terminal count mouse_x=+16, mouse_y=-5, input_pulse toggles once; next opportunity produces no toggle.
- Accumulation and carry: 10 packets of dX=+100 (status=0x08) within one sample -> emits +255, then +255, +255, +235 on successive opportunities; acc_x=0 afterward.
- Overflow and negative: status=0x58 (X sign+overflow), dX=0x00 -> raw_x=-256; after 9 such packets acc_x saturates at -2048, and 8 subsequent emits of -256 drain it to 0.
- Button-only emit: status=0x09, dX=dY=0 -> mouse_left=1 two cycles after the toggle edge; pulse toggles at the next opportunity with mouse_x=mouse_y=0. A repeat identical packet gives no further toggle.
- Collision: packet with dX=+20 decoded in the terminal-count cycle while acc_x=+300 -> mouse_x=+255 emitted; acc_x=+65 afterward.
